// File: rtl/fifo_flush_pack_sync_if.sv
// fifo_flush_pack_sync_if
//   Bundles the write, read and status signals of the width-upsizing FIFO.
//   Optional lane-mask output is present only when FIFO_LANE_MASK_EN is defined.
//   Ports (modport slave = FIFO side, master = user side):
//     fifo_wr_valid_i / fifo_wr_data_i  write beat strobe and data (IN_W)
//     fifo_rd_valid_i                   pop head word
//     fifo_flush_i                      commit partially packed word
//     fifo_rd_data_o                    head word (IN_W*RATIO, show-ahead)
//     fifo_empty_o / fifo_full_o        occupancy flags
//     fifo_curr_o                       lanes filled in packer
//     fifo_count_o                      stored words
//     fifo_ovf_o                        sticky dropped-beat flag
//     fifo_rd_mask_o                    valid lanes of head word (FIFO_LANE_MASK_EN only)
interface fifo_flush_pack_sync_if #(
  parameter int IN_W  = 4,
  parameter int RATIO = 8,
  parameter int DEPTH = 8
);
  logic                      fifo_wr_valid_i;
  logic [IN_W-1:0]           fifo_wr_data_i;
  logic                      fifo_rd_valid_i;
  logic                      fifo_flush_i;
  logic [IN_W*RATIO-1:0]     fifo_rd_data_o;
  logic                      fifo_empty_o;
  logic                      fifo_full_o;
  logic [$clog2(RATIO):0]    fifo_curr_o;
  logic [$clog2(DEPTH):0]    fifo_count_o;
  logic                      fifo_ovf_o;
`ifdef FIFO_LANE_MASK_EN
  logic [RATIO-1:0]          fifo_rd_mask_o;

  modport slave (
    input  fifo_wr_valid_i, fifo_wr_data_i, fifo_rd_valid_i, fifo_flush_i,
    output fifo_rd_data_o, fifo_empty_o, fifo_full_o, fifo_curr_o, fifo_count_o,
           fifo_ovf_o, fifo_rd_mask_o
  );
  modport master (
    output fifo_wr_valid_i, fifo_wr_data_i, fifo_rd_valid_i, fifo_flush_i,
    input  fifo_rd_data_o, fifo_empty_o, fifo_full_o, fifo_curr_o, fifo_count_o,
           fifo_ovf_o, fifo_rd_mask_o
  );
`else
  modport slave (
    input  fifo_wr_valid_i, fifo_wr_data_i, fifo_rd_valid_i, fifo_flush_i,
    output fifo_rd_data_o, fifo_empty_o, fifo_full_o, fifo_curr_o, fifo_count_o,
           fifo_ovf_o
  );
  modport master (
    output fifo_wr_valid_i, fifo_wr_data_i, fifo_rd_valid_i, fifo_flush_i,
    input  fifo_rd_data_o, fifo_empty_o, fifo_full_o, fifo_curr_o, fifo_count_o,
           fifo_ovf_o
  );
`endif
endinterface

// File: rtl/fifo_flush_pack_sync.sv
// fifo_flush_pack_sync
//   Single-clock width-upsizing FIFO with flush. RATIO narrow beats of IN_W bits are
//   packed LSB lane first into one IN_W*RATIO word and stored in a DEPTH-entry buffer.
//   A flush commits a partially packed word, zero padded in the unfilled lanes.
//   Optional feature macro: FIFO_LANE_MASK_EN adds fifo_rd_mask_o (valid lanes of the
//   head word) and widens each storage entry by RATIO bits.
//   Ports:
//     clock  single clock, rising edge
//     reset  asynchronous, active-high
//     bus    fifo_flush_pack_sync_if.slave (write/read/flush strobes and status)
module fifo_flush_pack_sync #(
  parameter int IN_W  = 4,
  parameter int RATIO = 8,
  parameter int DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  fifo_flush_pack_sync_if.slave bus
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = $clog2(RATIO) + 1;
  localparam int LW    = $clog2(RATIO);
  localparam int PW    = $clog2(DEPTH);
  localparam int NW    = PW + 1;
`ifdef FIFO_LANE_MASK_EN
  localparam int MW    = OUT_W + RATIO;

  // Mask with the lowest n lanes set; n==RATIO yields all ones.
  function automatic logic [RATIO-1:0] lane_mask(input logic [CW-1:0] n);
    logic [RATIO-1:0] m;
    for (int i = 0; i < RATIO; i++) begin
      m[i] = (n > CW'(i));
    end
    return m;
  endfunction
`else
  localparam int MW    = OUT_W;
`endif

  logic [OUT_W-1:0] packer_r;
  logic [CW-1:0]    curr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [NW-1:0]    count_r;
  logic             full_r;
  logic             empty_r;
  logic             ovf_r;
  logic [MW-1:0]    mem_r [DEPTH];

  logic             wr_acc_s;
  logic             pop_s;
  logic             complete_s;
  logic             flush_push_s;
  logic             push_s;
  logic [OUT_W-1:0] packed_s;
  logic [CW-1:0]    lanes_s;
  logic [NW-1:0]    count_nxt_s;
  logic [MW-1:0]    store_s;
  logic [MW-1:0]    head_s;

  // Accept/pop decisions and the packer contents including any same-edge beat.
  always_comb begin
    wr_acc_s = bus.fifo_wr_valid_i && !full_r;
    pop_s    = bus.fifo_rd_valid_i && !empty_r;
    packed_s = packer_r;
    if (wr_acc_s) begin
      packed_s[curr_r[LW-1:0]*IN_W +: IN_W] = bus.fifo_wr_data_i;
      lanes_s = curr_r + CW'(1);
    end else begin
      lanes_s = curr_r;
    end
    complete_s   = wr_acc_s && (curr_r == CW'(RATIO - 1));
    // A beat that completes a word while flush is high still yields a single push.
    flush_push_s = bus.fifo_flush_i && !full_r && (lanes_s != {CW{1'b0}});
    push_s       = complete_s || flush_push_s;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + NW'(1);
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - NW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Storage entry: lane mask (optional) above the packed word.
  always_comb begin
`ifdef FIFO_LANE_MASK_EN
    store_s = {lane_mask(lanes_s), packed_s};
`else
    store_s = packed_s;
`endif
  end

  // Packer, pointers, occupancy and sticky overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      packer_r <= {OUT_W{1'b0}};
      curr_r   <= {CW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {NW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        packer_r <= {OUT_W{1'b0}};
        curr_r   <= {CW{1'b0}};
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else if (wr_acc_s) begin
        packer_r <= packed_s;
        curr_r   <= curr_r + CW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      if (bus.fifo_wr_valid_i && full_r) begin
        ovf_r <= 1'b1;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == NW'(DEPTH));
      empty_r <= (count_nxt_s == {NW{1'b0}});
    end
  end

  // Word storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= store_s;
    end
  end

  // Show-ahead head entry and status outputs.
  always_comb begin
    head_s              = mem_r[rd_ptr_r];
    bus.fifo_rd_data_o  = head_s[OUT_W-1:0];
    bus.fifo_empty_o    = empty_r;
    bus.fifo_full_o     = full_r;
    bus.fifo_curr_o     = curr_r;
    bus.fifo_count_o    = count_r;
    bus.fifo_ovf_o      = ovf_r;
`ifdef FIFO_LANE_MASK_EN
    if (empty_r) begin
      bus.fifo_rd_mask_o = {RATIO{1'b0}};
    end else begin
      bus.fifo_rd_mask_o = head_s[MW-1:OUT_W];
    end
`endif
  end
endmodule

// File: tb/tb_fifo_flush_pack_sync.sv
// Self-checking bench for fifo_flush_pack_sync: directed scenarios plus random traffic,
// expected words queued by a beat-list reference model and checked by a read monitor.
module tb_fifo_flush_pack_sync;
  localparam int IN_W  = 4;
  localparam int RATIO = 8;
  localparam int DEPTH = 8;
  localparam int OUT_W = IN_W * RATIO;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fifo_flush_pack_sync_if #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH)) bus ();
  fifo_flush_pack_sync #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [OUT_W-1:0] exp_q  [$];
  logic [RATIO-1:0] expm_q [$];
  logic [IN_W-1:0]  pend   [$];
  int               m_count;
  bit               m_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    exp_q.delete();
    expm_q.delete();
    m_count = 0;
    m_ovf   = 1'b0;
  endtask

  // Drive one cycle, update the reference model, then check status after the edge.
  task automatic step(input bit wv, input logic [IN_W-1:0] wd, input bit rv, input bit fl);
    bit               m_full;
    bit               pop;
    bit               push;
    logic [OUT_W-1:0] word;
    logic [RATIO-1:0] mask;
    bus.fifo_wr_valid_i = wv;
    bus.fifo_wr_data_i  = wd;
    bus.fifo_rd_valid_i = rv;
    bus.fifo_flush_i    = fl;
    m_full = (m_count == DEPTH);
    pop    = rv && (m_count > 0);
    if (wv && m_full) m_ovf = 1'b1;
    if (wv && !m_full) pend.push_back(wd);
    push = (pend.size() == RATIO) || (fl && !m_full && pend.size() > 0);
    if (push) begin
      word = '0;
      mask = '0;
      for (int i = 0; i < pend.size(); i++) begin
        word[i*IN_W +: IN_W] = pend[i];
        mask[i] = 1'b1;
      end
      exp_q.push_back(word);
      expm_q.push_back(mask);
      pend.delete();
      m_count++;
    end
    if (pop) m_count--;
    @(posedge clock);
    #1;
    chk("count", 64'(bus.fifo_count_o), 64'(m_count));
    chk("curr",  64'(bus.fifo_curr_o),  64'(pend.size()));
    chk("full",  64'(bus.fifo_full_o),  64'(m_count == DEPTH));
    chk("empty", 64'(bus.fifo_empty_o), 64'(m_count == 0));
    chk("ovf",   64'(bus.fifo_ovf_o),   64'(m_ovf));
  endtask

  // Read monitor: every accepted pop is compared against the oldest expected word.
  always @(negedge clock) begin
    if (!reset && bus.fifo_rd_valid_i && !bus.fifo_empty_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_underflow actual=pop required=no_word_expected");
      end else begin
        chk("rd_data", 64'(bus.fifo_rd_data_o), 64'(exp_q.pop_front()));
`ifdef FIFO_LANE_MASK_EN
        chk("rd_mask", 64'(bus.fifo_rd_mask_o), 64'(expm_q.pop_front()));
`else
        void'(expm_q.pop_front());
`endif
      end
    end
  end

  task automatic drain();
    while (m_count > 0) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [IN_W-1:0] a;
    bus.fifo_wr_valid_i = 1'b0;
    bus.fifo_wr_data_i  = '0;
    bus.fifo_rd_valid_i = 1'b0;
    bus.fifo_flush_i    = 1'b0;
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_empty", 64'(bus.fifo_empty_o), 64'd1);
    chk("rst_full",  64'(bus.fifo_full_o),  64'd0);
    chk("rst_curr",  64'(bus.fifo_curr_o),  64'd0);
    chk("rst_count", 64'(bus.fifo_count_o), 64'd0);
    chk("rst_ovf",   64'(bus.fifo_ovf_o),   64'd0);

    // Full word 1..8.
    for (int i = 1; i <= 8; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
    chk("t2_data", 64'(bus.fifo_rd_data_o), 64'h87654321);
    chk("t2_curr", 64'(bus.fifo_curr_o), 64'd0);
`ifdef FIFO_LANE_MASK_EN
    chk("t2_mask", 64'(bus.fifo_rd_mask_o), 64'hFF);
`endif
    step(1'b0, '0, 1'b1, 1'b0);

    // Partial word, idle, flush, second flush is a no-op.
    step(1'b1, 4'hA, 1'b0, 1'b0);
    step(1'b1, 4'h3, 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("t3_data", 64'(bus.fifo_rd_data_o), 64'h0000053A);
`ifdef FIFO_LANE_MASK_EN
    chk("t3_mask", 64'(bus.fifo_rd_mask_o), 64'h07);
`endif
    step(1'b0, '0, 1'b0, 1'b1);
    chk("t3_count", 64'(bus.fifo_count_o), 64'd1);
    drain();

    // Flush held for three edges with a same-edge beat on the first.
    step(1'b1, 4'hA, 1'b0, 1'b0);
    step(1'b1, 4'h3, 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("t4_count", 64'(bus.fifo_count_o), 64'd1);
    chk("t4_data", 64'(bus.fifo_rd_data_o), 64'h0000053A);
    drain();

    // Overfill: 8*DEPTH+1 beats, then flush and write while full.
    for (int i = 0; i < 8 * DEPTH + 1; i++) step(1'b1, 4'($urandom_range(15)), 1'b0, 1'b0);
    chk("t5_full", 64'(bus.fifo_full_o), 64'd1);
    chk("t5_count", 64'(bus.fifo_count_o), 64'd8);
    chk("t5_ovf", 64'(bus.fifo_ovf_o), 64'd1);
    chk("t5_curr", 64'(bus.fifo_curr_o), 64'd0);
    step(1'b1, 4'h9, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t5_rd_full", 64'(bus.fifo_full_o), 64'd0);
    chk("t5_rd_count", 64'(bus.fifo_count_o), 64'd7);
    chk("t5_rd_ovf", 64'(bus.fifo_ovf_o), 64'd1);
    drain();

    // Push and pop on the same edge, read when empty, async reset mid-packing.
    for (int i = 0; i < 3 * RATIO; i++) step(1'b1, 4'($urandom_range(15)), 1'b0, 1'b0);
    for (int i = 0; i < RATIO - 1; i++) step(1'b1, 4'($urandom_range(15)), 1'b0, 1'b0);
    step(1'b1, 4'($urandom_range(15)), 1'b1, 1'b0);
    chk("t6_pushpop", 64'(bus.fifo_count_o), 64'd3);
    drain();
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t6_rd_empty", 64'(bus.fifo_count_o), 64'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 4'($urandom_range(15)), 1'b0, 1'b0);
    chk("t6_curr5", 64'(bus.fifo_curr_o), 64'd5);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_curr", 64'(bus.fifo_curr_o), 64'd0);
    chk("t6_rst_ovf", 64'(bus.fifo_ovf_o), 64'd0);
    model_reset();
    bus.fifo_wr_valid_i = 1'b0;
    bus.fifo_flush_i    = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      a = 4'($urandom_range(15));
      step($urandom_range(99) < 70, a, $urandom_range(99) < 35, $urandom_range(99) < 10);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    drain();
    chk("final_queue", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
